nibble_frame_tx: RTL and testbench

Serial frame transmitter for the nibble datapath. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out on a single idle-high line. Each frame is a start bit, then the data bits LSB first, then an optional even-parity bit, then a stop bit. Each bit is held for DIV clock cycles. It is the sending end of the nibble serial link; the matching frame receiver on the far side rebuilds the word.

---
 rtl/nibble_frame_tx.sv | 121 ++++++++++++
 tb/tb_nibble_frame_tx.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/nibble_frame_tx.sv
// Serial frame transmitter: start bit, WIDTH data bits LSB first, optional even parity, stop bit.
// Each bit lasts DIV clocks, and every output comes straight from a flop.
module nibble_frame_tx #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned DIV       = 4,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BIT_W = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               par_q, par_d;
  logic               tx_d, busy_d, done_d, in_ready_d;
  logic               bit_end;

  assign bit_end = (div_cnt_q == DIV_W'(DIV - 1));

  // The outputs are computed from the next state and registered. This way
  // tx, busy and done change on the same edge as the state they describe.
  always_comb begin
    // NOTE: every signal gets a default here first, so no path can infer a latch.
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    par_d     = par_q;

    if (state_q != IDLE) begin
      div_cnt_d = bit_end ? '0 : div_cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_d   = START;
          shreg_d   = in_data;
          par_d     = ^in_data;
          bit_cnt_d = '0;
          div_cnt_d = '0;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_W'(WIDTH - 1)) begin
            state_d = PARITY_EN ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase

    busy_d     = (state_d != IDLE);
    in_ready_d = (state_d == IDLE);
    done_d     = (state_d == STOP) && (div_cnt_d == DIV_W'(DIV - 1));
  end

  // NOTE: sequential state uses non-blocking assignments so that all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      par_q     <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      par_q     <= par_d;
      tx        <= tx_d;
      busy      <= busy_d;
      done      <= done_d;
      in_ready  <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_nibble_frame_tx.sv
// Directed bench for nibble_frame_tx: three instances cover the default, no-parity and DIV=1 builds.
// Each cycle it compares the packed outputs {tx,busy,done,in_ready} against hand-written frames.
module tb_nibble_frame_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'h0;
  int         sel = 0;

  logic [2:0] valid_v, ready_v, tx_v, busy_v, done_v;
  logic       cur_tx, cur_busy, cur_done, cur_ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign valid_v[0] = in_valid && (sel == 0);
  assign valid_v[1] = in_valid && (sel == 1);
  assign valid_v[2] = in_valid && (sel == 2);

  nibble_frame_tx #(.WIDTH(4), .DIV(4), .PARITY_EN(1'b1)) u_main (
    .clk(clk), .rst_n(rst_n), .in_valid(valid_v[0]), .in_ready(ready_v[0]),
    .in_data(in_data), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  nibble_frame_tx #(.WIDTH(4), .DIV(4), .PARITY_EN(1'b0)) u_nopar (
    .clk(clk), .rst_n(rst_n), .in_valid(valid_v[1]), .in_ready(ready_v[1]),
    .in_data(in_data), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  nibble_frame_tx #(.WIDTH(4), .DIV(1), .PARITY_EN(1'b1)) u_div1 (
    .clk(clk), .rst_n(rst_n), .in_valid(valid_v[2]), .in_ready(ready_v[2]),
    .in_data(in_data), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  always_comb begin
    cur_tx    = tx_v[sel];
    cur_busy  = busy_v[sel];
    cur_done  = done_v[sel];
    cur_ready = ready_v[sel];
  end

  // Frame bits indexed by bit slot: [0] = start, then data LSB first, parity, stop.
  typedef struct {
    int         dut;
    logic [3:0] data;
    logic [6:0] bits;
    int         nbits;
    int         div;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] outs();
    return {cur_tx, cur_busy, cur_done, cur_ready};
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!cur_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_ready", {31'd0, cur_ready}, 32'd1);
  endtask

  // Call this in cycle 1 (#1 after the accept edge). It ends in cycle F+1.
  task automatic check_frame(input string name, input logic [6:0] bits, input int nbits, input int div);
    int f = nbits * div;
    for (int c = 1; c <= f; c++) begin
      if (c == 2) in_data = ~in_data;
      check($sformatf("%s_c%0d", name, c), {28'd0, outs()},
            {28'd0, bits[(c - 1) / div], 1'b1, (c == f), 1'b0});
      @(posedge clk); #1;
    end
    check($sformatf("%s_after", name), {28'd0, outs()}, 32'b1001);
  endtask

  task automatic send(input string name, input vec_t v);
    sel = v.dut;
    wait_ready();
    in_data  = v.data;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_frame(name, v.bits, v.nbits, v.div);
  endtask

  initial begin
    vecs[0] = '{0, 4'hA, 7'b1010100, 7, 4};
    vecs[1] = '{0, 4'h7, 7'b1101110, 7, 4};
    vecs[2] = '{1, 4'h7, 7'b0101110, 6, 4};
    vecs[3] = '{2, 4'h5, 7'b1001010, 7, 1};
    vecs[4] = '{2, 4'hF, 7'b1011110, 7, 1};
    vecs[5] = '{0, 4'h0, 7'b1000000, 7, 4};

    // Reset state, then in_ready comes up on the first edge after release.
    #2 rst_n = 1'b0;
    #2 check("reset_outs", {28'd0, outs()}, 32'b1000);
    #18 rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", {28'd0, outs()}, 32'b1001);

    // Idle stability.
    for (int i = 0; i < 100; i++) begin
      check($sformatf("idle_%0d", i), {28'd0, outs()}, 32'b1001);
      @(posedge clk); #1;
    end

    for (int i = 0; i < 6; i++) send($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back: in_valid stays high, so the second accept lands right after one idle cycle.
    sel = 0;
    wait_ready();
    in_data  = 4'h3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    check_frame("b2b_first", 7'b1000110, 7, 4);
    in_data = 4'hC;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_frame("b2b_second", 7'b1011000, 7, 4);

    // Reset in the middle of the DATA bits of 4'hF.
    sel = 0;
    wait_ready();
    in_data  = 4'hF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c < 7; c++) begin
      @(posedge clk); #1;
    end
    check("mid_frame_tx_data", {31'd0, cur_tx}, 32'd1);
    check("mid_frame_busy", {31'd0, cur_busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("abort_async", {28'd0, outs()}, 32'b1000);
    @(posedge clk); #1;
    check("abort_held", {28'd0, outs()}, 32'b1000);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_ready", {28'd0, outs()}, 32'b1001);
    send("after_abort", '{0, 4'h1, 7'b1100010, 7, 4});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
